// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display source stage.
// Imported by the interface, the prescaler and the top-level counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned VALUE_W     = 20;
    localparam int unsigned MAX_DISPLAY = 999999;

    // Clock cycles per count step; callers must keep the ratio integral and >= 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Command pulses in, display value and status flags out.
// The master drives the commands; the slave is the stopwatch itself.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic               start_stop;
    logic               lap;
    logic               clear;
    logic [VALUE_W-1:0] value;
    logic               running;
    logic               lap_active;
    logic               overflow;

    modport master (
        output start_stop, lap, clear,
        input  value, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
        output value, running, lap_active, overflow
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the clock down to one-cycle count ticks; phase is held while disabled
// and forced to zero by clr.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clr,
    output logic tick
);
    localparam int unsigned      CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch source stage: start/stop/lap/clear control, a wrapping binary count
// capped at MAX_COUNT, and a registered display value for the BCD converter.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned MAX_COUNT = MAX_DISPLAY
) (
    input logic                clk,
    input logic                rst,
    stopwatch_counter_if.slave bus
);
    localparam int unsigned        DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_COUNT);

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] count_q, count_d;
    logic [VALUE_W-1:0] lap_reg_q, lap_reg_d;
    logic               lap_active_q, lap_active_d;
    logic               overflow_q, overflow_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               running_q, running_d;
    logic               tick;

    // Prescaler sits at zero whenever idle so the first tick lands DIV cycles after start.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == RUN),
        .clr    (bus.clear || (state_q == IDLE)),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.start_stop) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Count, overflow and lap capture; the count keeps running under a frozen lap.
    always_comb begin
        count_d      = count_q;
        overflow_d   = overflow_q;
        lap_reg_d    = lap_reg_q;
        lap_active_d = lap_active_q;
        if (bus.clear) begin
            count_d      = '0;
            overflow_d   = 1'b0;
            lap_reg_d    = '0;
            lap_active_d = 1'b0;
        end else begin
            if (tick) begin
                if (count_q == MAX_V) begin
                    count_d    = '0;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            if (bus.lap && (state_q != IDLE)) begin
                if (lap_active_q) begin
                    lap_active_d = 1'b0;
                end else begin
                    lap_reg_d    = count_q;
                    lap_active_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        value_d   = lap_active_d ? lap_reg_d : count_d;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            overflow_q   <= 1'b0;
            lap_reg_q    <= '0;
            lap_active_q <= 1'b0;
            value_q      <= '0;
            running_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            lap_reg_q    <= lap_reg_d;
            lap_active_q <= lap_active_d;
            value_q      <= value_d;
            running_q    <= running_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.running    = running_q;
    assign bus.lap_active = lap_active_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Upstream source stage for the 6-digit display path. Counts prescaled time ticks in binary and presents a 20-bit value, capped at 999999, to the binary-to-6-digit BCD converter. The converter's digits then go through the per-digit 7-segment decoders. Provides start/stop, lap-freeze and clear control from single-cycle command pulses.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz (centiseconds); DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
MAX_COUNT, 999999, last count value before wrap; must be <= 999999 (largest displayable value)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start_stop  input  1  single-cycle command pulse, already synchronised and debounced upstream
lap  input  1  single-cycle command pulse: freeze or release the displayed value
clear  input  1  single-cycle command pulse: return to the idle state with zero count
value  output  20  registered binary value, feeds the BCD converter's binary input
running  output  1  1 while in RUN
lap_active  output  1  1 while the displayed value is frozen
overflow  output  1  sticky; set when the count wraps past MAX_COUNT

Behaviour:
- Reset and clear: one clock, one cycle. Sets state=IDLE, count=0, prescaler=0, lap_reg=0, lap_active=0, overflow=0. Output reset values: value=0, running=0, lap_active=0, overflow=0.
- Reset mid-operation has exactly the same effect as clear.
- State machine:
  - IDLE -start_stop-> RUN
  - RUN -start_stop-> PAUSE
  - PAUSE -start_stop-> RUN
  - clear -> IDLE from any state
- Command priority: rst > clear > start_stop/lap. clear discards any start_stop or lap in the same cycle.
- Prescaler:
  - Counts 0..DIV-1, but only in RUN. It holds its value in PAUSE and is 0 in IDLE.
  - tick = (state==RUN) && (prescaler==DIV-1).
  - The prescaler wraps to 0 on tick.
  - The first tick comes DIV cycles after the start_stop edge that enters RUN.
- Count:
  - On tick, count = count+1.
  - If count==MAX_COUNT at the tick, count becomes 0 and overflow becomes 1. overflow stays 1 until clear or rst.
  - Count width is 20 bits and is never above MAX_COUNT.
- Lap:
  - In RUN or PAUSE with lap_active=0: lap_reg=count (the pre-increment value if a tick happens in the same cycle), and lap_active=1.
  - With lap_active=1: lap releases the freeze (lap_active=0). The underlying count has kept running throughout.
  - lap in IDLE is ignored.
  - lap and start_stop in the same cycle: both take effect.
- Output:
  - value is registered: value = lap_active ? lap_reg : count, using the next-state values.
  - value therefore reflects a tick or lap in the clock edge that follows it (latency 1).
  - running and lap_active are registered with the same timing.
- A start_stop arriving while the prescaler is mid-period in PAUSE resumes from the held prescaler value; no partial tick is lost or added.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum {IDLE, RUN, PAUSE}
  - VALUE_W=20
  - MAX_DISPLAY=999999
  - a function computing DIV from CLK_HZ and TICK_HZ
- Sub-module tick_prescaler (clk, rst, enable, clr → tick), parameterised by DIV. Counter width is $clog2(DIV).
- The top-level module holds the FSM, the count, the lap register and the output register.

Test Plan:
(All with CLK_HZ=10, TICK_HZ=1 → DIV=10, unless noted.)
- Reset: rst high for 2 cycles → value=0, running=0, lap_active=0, overflow=0. All command pulses during rst are ignored.
- Start/stop: start_stop at cycle 0, then 35 cycles → value=3, running=1. start_stop again, wait 50 cycles → value stays 3, running=0. start_stop again → value=4 exactly 5 cycles later (held prescaler resumes).
- Lap: run to value=7, pulse lap → value holds 7, lap_active=1 for 40 cycles. Pulse lap again → value=11 the next cycle.
- Wrap: MAX_COUNT=15, run 16 ticks → value goes 15 then 0, and overflow=1. overflow stays 1 until clear, then returns to 0.
- Priority: clear and start_stop in the same cycle while in RUN → IDLE, value=0, running=0. Tick and lap in the same cycle at count=5 → lap value 5, internal count 6.
- Mid-operation reset: rst asserted while RUN with lap_active=1 → all outputs 0 on the next edge. A later start_stop counts from 0.
